// File: rtl/baud_frac_gen.sv
// baud_frac_gen: fractional baud-rate tick generator.
// A phase accumulator adds `inc` every enabled cycle; each carry out of the
// accumulator is one oversample tick. An oversample counter divides those
// ticks into baud periods and marks the period end and its midpoint.
// Increment updates are staged through a ready/valid handshake and only
// take effect at a baud boundary, on resync, or while counting is disabled,
// so a period in progress always finishes with the rate it started with.
// Build option: define BAUD_FRAC_GEN_HALF_TICK_EN to generate half_tick;
// without it half_tick is tied low and its compare logic is not built.
module baud_frac_gen #(
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned RESET_INC  = 79164837
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             resync,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             os_tick,
  output logic             baud_tick,
  output logic             half_tick
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [ACC_W-1:0] RESET_INC_W = ACC_W'(RESET_INC);
  localparam logic [CNT_W-1:0] OS_LAST     = CNT_W'(OVERSAMPLE - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] pend_inc;
  logic             pend;
  logic [CNT_W-1:0] os_cnt;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             step;
  logic             os_hit;
  logic             wrap;
  logic             accept;
  logic             apply_now;

  // Accumulator sum, tick qualification and handshake decode
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, inc};
    carry     = sum[ACC_W];
    step      = en && !resync;
    os_hit    = step && carry;
    wrap      = os_hit && (os_cnt == OS_LAST);
    accept    = cfg_valid && !pend;
    apply_now = wrap || resync || !en;
  end

  assign cfg_ready = !pend;

  // Phase accumulator and oversample counter; resync wins over en
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      os_cnt <= '0;
    end else if (resync) begin
      acc    <= '0;
      os_cnt <= '0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
      if (carry) begin
        os_cnt <= wrap ? '0 : os_cnt + 1'b1;
      end
    end
  end

  // Increment staging: a pending value lands only at a safe point
  always_ff @(posedge clk) begin
    if (rst) begin
      inc      <= RESET_INC_W;
      pend_inc <= '0;
      pend     <= 1'b0;
    end else if (pend && apply_now) begin
      inc  <= pend_inc;
      pend <= 1'b0;
    end else if (accept && (resync || !en)) begin
      // Already at a safe point: take the new value directly, stay ready.
      inc <= cfg_inc;
    end else if (accept) begin
      pend_inc <= cfg_inc;
      pend     <= 1'b1;
    end
  end

  // Registered oversample and baud-end pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
    end else begin
      os_tick   <= os_hit;
      baud_tick <= wrap;
    end
  end

`ifdef BAUD_FRAC_GEN_HALF_TICK_EN
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);

  // Registered mid-period pulse: carry moving os_cnt into the second half
  always_ff @(posedge clk) begin
    if (rst) begin
      half_tick <= 1'b0;
    end else begin
      half_tick <= os_hit && (os_cnt == HALF_LAST);
    end
  end
`else
  assign half_tick = 1'b0;
`endif

endmodule

// File: tb/tb_baud_frac_gen.sv
// Directed bench for baud_frac_gen at ACC_W=8, OVERSAMPLE=4, RESET_INC=128.
module tb_baud_frac_gen;

  localparam int ACC_W = 8;

`ifdef BAUD_FRAC_GEN_HALF_TICK_EN
  localparam bit HALF_EN = 1'b1;
`else
  localparam bit HALF_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             en;
  logic             resync;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             os_tick;
  logic             baud_tick;
  logic             half_tick;

  int n_chk;
  int n_fail;

  baud_frac_gen #(
    .ACC_W      (ACC_W),
    .OVERSAMPLE (4),
    .RESET_INC  (128)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .resync    (resync),
    .cfg_inc   (cfg_inc),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .os_tick   (os_tick),
    .baud_tick (baud_tick),
    .half_tick (half_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cycles until baud_tick is seen; -1 if it never shows within max_cyc
  task automatic wait_baud(input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!baud_tick && n < max_cyc);
    if (!baud_tick) n = -1;
  endtask

  int n;
  int os_cnt_seen;
  int baud_cnt_seen;
  int bad_int;
  int last_os;
  int any_tick;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1; en = 1'b1; resync = 1'b0; cfg_inc = '0; cfg_valid = 1'b0;
    tick();
    tick();
    chk("rst_os", int'(os_tick), 0);
    chk("rst_baud", int'(baud_tick), 0);
    chk("rst_half", int'(half_tick), 0);
    chk("rst_ready", int'(cfg_ready), 1);

    // inc=128: os every 2nd, baud every 8th, half 4 after baud
    rst = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      chk($sformatf("os_c%0d", i), int'(os_tick), int'(i % 2 == 0));
      chk($sformatf("baud_c%0d", i), int'(baud_tick), int'(i % 8 == 0));
      chk($sformatf("half_c%0d", i), int'(half_tick), int'(HALF_EN && (i % 8 == 4)));
    end

    // mid-period update to 64; a second offer while pending is ignored
    tick(); tick(); tick();
    cfg_valid = 1'b1; cfg_inc = 8'd64;
    tick();
    cfg_valid = 1'b0;
    chk("upd_ready_lo0", int'(cfg_ready), 0);
    tick();
    cfg_valid = 1'b1; cfg_inc = 8'd200;
    tick();
    chk("upd_ready_lo1", int'(cfg_ready), 0);
    cfg_valid = 1'b0;
    tick();
    chk("upd_ready_lo2", int'(cfg_ready), 0);
    chk("upd_no_baud", int'(baud_tick), 0);
    tick();
    chk("upd_baud", int'(baud_tick), 1);
    chk("upd_ready_hi", int'(cfg_ready), 1);
    wait_baud(40, n);
    chk("upd_period16", n, 16);

    // accept+apply with en=0: ready stays high, 128 active next cycle
    en = 1'b0; cfg_valid = 1'b1; cfg_inc = 8'd128;
    tick();
    cfg_valid = 1'b0;
    chk("imm_ready", int'(cfg_ready), 1);
    chk("imm_frozen_os", int'(os_tick), 0);
    en = 1'b1;
    wait_baud(40, n);
    chk("imm_period8", n, 8);

    // resync 3 cycles after baud (would have been a carry cycle)
    tick(); tick(); tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("rsy_os", int'(os_tick), 0);
    chk("rsy_baud", int'(baud_tick), 0);
    wait_baud(40, n);
    chk("rsy_period8", n, 8);

    // reset with an update pending: pending discarded, RESET_INC back
    tick();
    cfg_valid = 1'b1; cfg_inc = 8'd32;
    tick();
    cfg_valid = 1'b0;
    chk("rpd_ready_lo", int'(cfg_ready), 0);
    rst = 1'b1;
    tick();
    chk("rpd_os", int'(os_tick), 0);
    chk("rpd_baud", int'(baud_tick), 0);
    chk("rpd_half", int'(half_tick), 0);
    chk("rpd_ready", int'(cfg_ready), 1);
    rst = 1'b0;
    wait_baud(60, n);
    chk("rpd_period8", n, 8);

    // inc=0 gives no ticks
    en = 1'b0; cfg_valid = 1'b1; cfg_inc = 8'd0;
    tick();
    cfg_valid = 1'b0; en = 1'b1;
    any_tick = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (os_tick || baud_tick || half_tick) any_tick++;
    end
    chk("zero_inc_ticks", any_tick, 0);

    // inc=96 from a clean reset, 3000 enabled cycles
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b1; cfg_inc = 8'd96;
    tick();
    cfg_valid = 1'b0; en = 1'b1;
    os_cnt_seen = 0; baud_cnt_seen = 0; bad_int = 0; last_os = -1;
    for (int i = 1; i <= 3000; i++) begin
      tick();
      if (os_tick) begin
        os_cnt_seen++;
        if (last_os >= 0 && (i - last_os < 2 || i - last_os > 3)) bad_int++;
        last_os = i;
      end
      if (baud_tick) baud_cnt_seen++;
    end
    chk("frac_os_count", os_cnt_seen, 1125);
    chk("frac_baud_count", baud_cnt_seen, 281);
    chk("frac_bad_intervals", bad_int, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
